// File: rtl/multimode_counter_game.sv
// ---------------------------------------------------------------------------
// multimode_counter_game
//   Up/down counter game. Each enabled step moves count by +1, +2, -1 or -2,
//   wrapping modulo 2^WIDTH. A step landing on all-ones pulses winner and
//   bumps the win tally. A step landing on all-zeros pulses loser and bumps
//   the lose tally. When either tally reaches LIMIT the game ends: gameover
//   rises, who names the side, and the counter halts.
//
// Optional feature macro: MMC_AUTORESTART_EN
//   When defined, gameover is held for one cycle. The next edge then starts a
//   fresh game from initial_val.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   init         in   synchronous load of initial_val, starts a new game
//   initial_val  in   [WIDTH-1:0] value loaded on init (and on auto-restart)
//   control      in   [1:0] 0:+1  1:+2  2:-1  3:-2
//   en           in   count enable
//   count        out  [WIDTH-1:0] current counter value
//   winner       out  one-cycle pulse, last step produced all-ones
//   loser        out  one-cycle pulse, last step produced all-zeros
//   gameover     out  a tally reached LIMIT
//   who          out  [1:0] 2'b10 winner side, 2'b01 loser side, 2'b00 none
// ---------------------------------------------------------------------------
module multimode_counter_game #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LIMIT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic [WIDTH-1:0] initial_val,
  input  logic [1:0]       control,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             winner,
  output logic             loser,
  output logic             gameover,
  output logic [1:0]       who
);

  localparam int unsigned TW = $clog2(LIMIT + 1);
  localparam logic [TW-1:0]    TALLY_MAX = TW'(LIMIT);
  localparam logic [WIDTH-1:0] ALL_ONES  = '1;
  localparam logic [WIDTH-1:0] ALL_ZEROS = '0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [TW-1:0]    win_q, win_d;
  logic [TW-1:0]    lose_q, lose_d;
  logic             winner_q, winner_d;
  logic             loser_q, loser_d;
  logic             gameover_q, gameover_d;
  logic [1:0]       who_q, who_d;
  logic [WIDTH-1:0] step_val;

  // Candidate next count for the current mode; wraps naturally at WIDTH bits
  always_comb begin
    step_val = count_q;
    case (control)
      2'd0:    step_val = count_q + WIDTH'(1);
      2'd1:    step_val = count_q + WIDTH'(2);
      2'd2:    step_val = count_q - WIDTH'(1);
      default: step_val = count_q - WIDTH'(2);
    endcase
  end

  // Next-state logic: init > halted > en > hold
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    win_d      = win_q;
    lose_d     = lose_q;
    winner_d   = 1'b0;
    loser_d    = 1'b0;
    gameover_d = gameover_q;
    who_d      = who_q;

    if (init) begin
      state_d    = ST_RUN;
      count_d    = initial_val;
      win_d      = '0;
      lose_d     = '0;
      gameover_d = 1'b0;
      who_d      = 2'b00;
    end else if (state_q == ST_HALT) begin
`ifdef MMC_AUTORESTART_EN
      // gameover has been visible for one cycle; start a fresh game
      state_d    = ST_RUN;
      count_d    = initial_val;
      win_d      = '0;
      lose_d     = '0;
      gameover_d = 1'b0;
      who_d      = 2'b00;
`else
      // Frozen until init or reset
      state_d    = ST_HALT;
`endif
    end else if (en) begin
      count_d = step_val;
      // Only the landed value counts; by-2 modes may jump over either extreme
      if (step_val == ALL_ONES) begin
        winner_d = 1'b1;
        win_d    = win_q + TW'(1);
        if (win_q + TW'(1) == TALLY_MAX) begin
          gameover_d = 1'b1;
          who_d      = 2'b10;
          state_d    = ST_HALT;
        end
      end else if (step_val == ALL_ZEROS) begin
        loser_d = 1'b1;
        lose_d  = lose_q + TW'(1);
        if (lose_q + TW'(1) == TALLY_MAX) begin
          gameover_d = 1'b1;
          who_d      = 2'b01;
          state_d    = ST_HALT;
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      count_q    <= '0;
      win_q      <= '0;
      lose_q     <= '0;
      winner_q   <= 1'b0;
      loser_q    <= 1'b0;
      gameover_q <= 1'b0;
      who_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      win_q      <= win_d;
      lose_q     <= lose_d;
      winner_q   <= winner_d;
      loser_q    <= loser_d;
      gameover_q <= gameover_d;
      who_q      <= who_d;
    end
  end

  assign count    = count_q;
  assign winner   = winner_q;
  assign loser    = loser_q;
  assign gameover = gameover_q;
  assign who      = who_q;

endmodule
